// File: rtl/alarm_pkg.sv
`default_nettype none
// ============================================================================
// Module  : alarm_pkg
// Purpose : Shared types and default timing constants for the alarm scheduler
// Revision: 1.0  initial release
// ============================================================================
package alarm_pkg;

  // Scheduler FSM states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RING   = 2'd1,
    ST_SNOOZE = 2'd2
  } state_t;

  // Wall-clock time as four BCD nibbles, hours tens first
  typedef struct packed {
    logic [3:0] h_tens;
    logic [3:0] h_units;
    logic [3:0] m_tens;
    logic [3:0] m_units;
  } bcd_time_t;

  // Default timing values, in minutes / counts
  localparam int unsigned DEF_SNOOZE_MIN = 5;
  localparam int unsigned DEF_MAX_SNOOZE = 3;
  localparam int unsigned DEF_RING_MIN   = 2;

endpackage
`default_nettype wire

// File: rtl/alarm_slot_bank.sv
`default_nettype none
// ============================================================================
// Module  : alarm_slot_bank
// Purpose : Per-slot alarm time/enable storage and current-time comparators
// Revision: 1.0  initial release
// ============================================================================
module alarm_slot_bank
  import alarm_pkg::*;
#(
  parameter int unsigned NUM_SLOTS = 4
) (
  input  logic                         clk,
  input  logic                         reset_,
  input  logic                         cfg_wr,
  input  logic [$clog2(NUM_SLOTS)-1:0] cfg_slot,
  input  bcd_time_t                    cfg_time,
  input  logic                         cfg_en,
  input  bcd_time_t                    cur_time,
  output logic [NUM_SLOTS-1:0]         match
);

  localparam int SLOT_W = $clog2(NUM_SLOTS);

  bcd_time_t              time_q [NUM_SLOTS];
  logic [NUM_SLOTS-1:0]   en_q;

  generate
    for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
      logic      sel;
      bcd_time_t time_d;
      logic      en_d;

      // Next value for this slot: load on a write addressed to it
      always_comb begin
        sel    = cfg_wr && (cfg_slot == SLOT_W'(i));
        time_d = sel ? cfg_time : time_q[i];
        en_d   = sel ? cfg_en   : en_q[i];
      end

      // Slot configuration registers
      always_ff @(posedge clk) begin
        if (reset_) begin
          time_q[i] <= '0;
          en_q[i]   <= 1'b0;
        end else begin
          time_q[i] <= time_d;
          en_q[i]   <= en_d;
        end
      end

      // A slot matches only while enabled and exactly equal to current time
      assign match[i] = en_q[i] && (time_q[i] == cur_time);
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/alarm_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : alarm_scheduler
// Purpose : Multi-slot alarm controller owning the buzzer; arbitrates matched
//           slots and sequences ring / snooze / stop
// Revision: 1.0  initial release
// ============================================================================
module alarm_scheduler
  import alarm_pkg::*;
#(
  parameter int unsigned NUM_SLOTS  = 4,
  parameter int unsigned SNOOZE_MIN = DEF_SNOOZE_MIN,
  parameter int unsigned MAX_SNOOZE = DEF_MAX_SNOOZE,
  parameter int unsigned RING_MIN   = DEF_RING_MIN
) (
  input  logic                         clk,
  input  logic                         reset_,
  input  logic                         minute_tick,
  input  logic [3:0]                   DigN0,
  input  logic [3:0]                   DigN1,
  input  logic [3:0]                   DigN2,
  input  logic [3:0]                   DigN3,
  input  logic                         cfg_wr,
  input  logic [$clog2(NUM_SLOTS)-1:0] cfg_slot,
  input  logic [15:0]                  cfg_time,
  input  logic                         cfg_en,
  input  logic                         STOP,
  input  logic                         Snooze,
  output logic                         buzz,
  output logic [$clog2(NUM_SLOTS)-1:0] active_slot,
  output logic                         busy,
  output logic [NUM_SLOTS-1:0]         pending,
  output logic [1:0]                   snooze_cnt
);

  localparam int         SLOT_W       = $clog2(NUM_SLOTS);
  localparam logic [3:0] C_SNOOZE_MIN = 4'(SNOOZE_MIN);
  localparam logic [3:0] C_RING_MIN   = 4'(RING_MIN);
  localparam logic [1:0] C_MAX_SNOOZE = 2'(MAX_SNOOZE);

  bcd_time_t            cur_time;
  logic [NUM_SLOTS-1:0] match;

  state_t               state_q, state_d;
  logic [SLOT_W-1:0]    active_q, active_d;
  logic [1:0]           snz_cnt_q, snz_cnt_d;
  logic [3:0]           ring_q, ring_d;
  logic [3:0]           snz_tmr_q, snz_tmr_d;
  logic [NUM_SLOTS-1:0] pending_q, pending_d;
  logic                 buzz_q, buzz_d;
  logic                 busy_q, busy_d;

  logic [NUM_SLOTS-1:0] cfg_mask;
  logic [NUM_SLOTS-1:0] grant_pool;
  logic [SLOT_W-1:0]    grant_idx;
  logic                 active_cfg;
  logic                 auto_snooze;

  assign cur_time = {DigN3, DigN2, DigN1, DigN0};

  alarm_slot_bank #(
    .NUM_SLOTS (NUM_SLOTS)
  ) u_bank (
    .clk      (clk),
    .reset_   (reset_),
    .cfg_wr   (cfg_wr),
    .cfg_slot (cfg_slot),
    .cfg_time (bcd_time_t'(cfg_time)),
    .cfg_en   (cfg_en),
    .cur_time (cur_time),
    .match    (match)
  );

  // Slot masks for config writes and lowest-index pending grant
  always_comb begin
    cfg_mask  = '0;
    grant_idx = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      cfg_mask[i] = cfg_wr && (cfg_slot == SLOT_W'(i));
    end
    // A slot being reconfigured this cycle loses its pending request
    grant_pool = pending_q & ~cfg_mask;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (grant_pool[i]) grant_idx = SLOT_W'(i);
    end
  end

  // FSM next state, counters and pending bookkeeping
  always_comb begin
    state_d     = state_q;
    active_d    = active_q;
    snz_cnt_d   = snz_cnt_q;
    ring_d      = ring_q;
    snz_tmr_d   = snz_tmr_q;
    active_cfg  = cfg_wr && (cfg_slot == active_q);
    auto_snooze = minute_tick && ((ring_q + 4'd1) == C_RING_MIN);

    unique case (state_q)
      ST_IDLE: begin
        if (|grant_pool) begin
          state_d   = ST_RING;
          active_d  = grant_idx;
          snz_cnt_d = 2'd0;
          ring_d    = 4'd0;
        end
      end
      ST_RING: begin
        if (active_cfg || STOP) begin
          state_d = ST_IDLE;
        end else if (Snooze || auto_snooze) begin
          // Once the snooze allowance is used up, a snooze ends the event;
          // a simultaneous tick is absorbed by the fresh timer load
          if (snz_cnt_q == C_MAX_SNOOZE) begin
            state_d = ST_IDLE;
          end else begin
            state_d   = ST_SNOOZE;
            snz_cnt_d = snz_cnt_q + 2'd1;
            snz_tmr_d = C_SNOOZE_MIN;
          end
        end else if (minute_tick) begin
          ring_d = ring_q + 4'd1;
        end
      end
      ST_SNOOZE: begin
        if (active_cfg || STOP) begin
          state_d = ST_IDLE;
        end else if (minute_tick) begin
          if (snz_tmr_q <= 4'd1) begin
            state_d   = ST_RING;
            ring_d    = 4'd0;
            snz_tmr_d = 4'd0;
          end else begin
            snz_tmr_d = snz_tmr_q - 4'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Set on match, then clear for config writes and the granted slot;
    // the slot currently owning the buzzer is never re-pended
    pending_d = pending_q;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (minute_tick && match[i] && !(busy_q && active_q == SLOT_W'(i))) begin
        pending_d[i] = 1'b1;
      end
      if (cfg_mask[i]) begin
        pending_d[i] = 1'b0;
      end
      if ((state_q == ST_IDLE) && (|grant_pool) && (grant_idx == SLOT_W'(i))) begin
        pending_d[i] = 1'b0;
      end
    end

    buzz_d = (state_d == ST_RING);
    busy_d = (state_d != ST_IDLE);
  end

  // State, counters and registered outputs
  always_ff @(posedge clk) begin
    if (reset_) begin
      state_q   <= ST_IDLE;
      active_q  <= '0;
      snz_cnt_q <= 2'd0;
      ring_q    <= 4'd0;
      snz_tmr_q <= 4'd0;
      pending_q <= '0;
      buzz_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      active_q  <= active_d;
      snz_cnt_q <= snz_cnt_d;
      ring_q    <= ring_d;
      snz_tmr_q <= snz_tmr_d;
      pending_q <= pending_d;
      buzz_q    <= buzz_d;
      busy_q    <= busy_d;
    end
  end

  assign buzz        = buzz_q;
  assign busy        = busy_q;
  assign active_slot = active_q;
  assign pending     = pending_q;
  assign snooze_cnt  = snz_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_alarm_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : tb_alarm_scheduler
// Purpose : Self-checking bench for alarm_scheduler with grant-order scoreboard
// Revision: 1.0  initial release
// ============================================================================
module tb_alarm_scheduler;

  logic        clk = 1'b0;
  logic        reset_ = 1'b1;
  logic        minute_tick = 1'b0;
  logic [3:0]  DigN0 = '0, DigN1 = '0, DigN2 = '0, DigN3 = '0;
  logic        cfg_wr = 1'b0;
  logic [1:0]  cfg_slot = '0;
  logic [15:0] cfg_time = '0;
  logic        cfg_en = 1'b0;
  logic        STOP = 1'b0;
  logic        Snooze = 1'b0;
  logic        buzz;
  logic [1:0]  active_slot;
  logic        busy;
  logic [3:0]  pending;
  logic [1:0]  snooze_cnt;

  int total = 0;
  int bad   = 0;
  int exp_q [$];

  alarm_scheduler #(
    .NUM_SLOTS (4), .SNOOZE_MIN (5), .MAX_SNOOZE (3), .RING_MIN (2)
  ) dut (
    .clk (clk), .reset_ (reset_), .minute_tick (minute_tick),
    .DigN0 (DigN0), .DigN1 (DigN1), .DigN2 (DigN2), .DigN3 (DigN3),
    .cfg_wr (cfg_wr), .cfg_slot (cfg_slot), .cfg_time (cfg_time), .cfg_en (cfg_en),
    .STOP (STOP), .Snooze (Snooze),
    .buzz (buzz), .active_slot (active_slot), .busy (busy),
    .pending (pending), .snooze_cnt (snooze_cnt)
  );

  always #5 clk = ~clk;

  // Advance one edge; inputs change and outputs are sampled 1ns after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic [1:0] slot, input logic [15:0] t, input logic en);
    cfg_wr = 1'b1; cfg_slot = slot; cfg_time = t; cfg_en = en;
    step();
    cfg_wr = 1'b0;
  endtask

  task automatic tick(input logic [15:0] t);
    {DigN3, DigN2, DigN1, DigN0} = t;
    minute_tick = 1'b1;
    step();
    minute_tick = 1'b0;
  endtask

  task automatic press_stop();
    STOP = 1'b1; step(); STOP = 1'b0;
  endtask

  task automatic press_snooze();
    Snooze = 1'b1; step(); Snooze = 1'b0;
  endtask

  // Bounded wait for an event to start
  task automatic wait_busy(input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      if (busy) begin ok = 1'b1; break; end
      step();
    end
    if (busy) ok = 1'b1;
  endtask

  task automatic test_reset();
    reset_ = 1'b1; step(); step(); reset_ = 1'b0;
    total++;
    if ({buzz, busy, active_slot, pending, snooze_cnt} !== 10'd0) begin
      bad++;
      $display("FAIL reset_outputs got=%b want=0", {buzz, busy, active_slot, pending, snooze_cnt});
    end
  endtask

  task automatic test_single();
    int exp_slot;
    cfg(2'd1, 16'h0730, 1'b1);
    step();
    tick(16'h0730);
    exp_q.push_back(1);
    total++;
    if (pending !== 4'b0010 || busy !== 1'b0) begin
      bad++; $display("FAIL single_pending got=%b busy=%b want=0010 busy=0", pending, busy);
    end
    step();
    exp_slot = exp_q.pop_front();
    total++;
    if (buzz !== 1'b1 || busy !== 1'b1 || active_slot !== 2'(exp_slot) || pending !== 4'b0) begin
      bad++; $display("FAIL single_ring buzz=%b busy=%b slot=%0d pend=%b want 1 1 %0d 0000",
                      buzz, busy, active_slot, pending, exp_slot);
    end
    press_stop();
    total++;
    if (buzz !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL single_stop buzz=%b busy=%b want 0 0", buzz, busy);
    end
  endtask

  task automatic test_overlap();
    int exp_slot;
    bit ok;
    cfg(2'd0, 16'h0600, 1'b1);
    cfg(2'd2, 16'h0600, 1'b1);
    tick(16'h0600);
    exp_q.push_back(0);
    exp_q.push_back(2);
    total++;
    if (pending !== 4'b0101) begin
      bad++; $display("FAIL overlap_pending got=%b want=0101", pending);
    end
    wait_busy(4, ok);
    exp_slot = exp_q.pop_front();
    total++;
    if (!ok || active_slot !== 2'(exp_slot) || pending !== 4'b0100 || buzz !== 1'b1) begin
      bad++; $display("FAIL overlap_first ok=%0d slot=%0d pend=%b buzz=%b want slot %0d pend 0100",
                      ok, active_slot, pending, buzz, exp_slot);
    end
    press_stop();
    total++;
    if (busy !== 1'b0 || pending !== 4'b0100) begin
      bad++; $display("FAIL overlap_idle_gap busy=%b pend=%b want 0 0100", busy, pending);
    end
    wait_busy(4, ok);
    exp_slot = exp_q.pop_front();
    total++;
    if (!ok || active_slot !== 2'(exp_slot) || pending !== 4'b0000) begin
      bad++; $display("FAIL overlap_second ok=%0d slot=%0d pend=%b want slot %0d pend 0000",
                      ok, active_slot, pending, exp_slot);
    end
    press_stop();
  endtask

  task automatic test_snooze();
    bit ok;
    int exp_slot;
    cfg(2'd2, 16'h0600, 1'b0);
    tick(16'h0600);
    exp_q.push_back(0);
    wait_busy(4, ok);
    exp_slot = exp_q.pop_front();
    total++;
    if (!ok || active_slot !== 2'(exp_slot) || buzz !== 1'b1) begin
      bad++; $display("FAIL snooze_start ok=%0d slot=%0d buzz=%b want slot %0d", ok, active_slot, buzz, exp_slot);
    end
    for (int k = 1; k <= 3; k++) begin
      press_snooze();
      total++;
      if (buzz !== 1'b0 || busy !== 1'b1 || snooze_cnt !== 2'(k)) begin
        bad++; $display("FAIL snooze_enter buzz=%b busy=%b cnt=%0d want 0 1 %0d", buzz, busy, snooze_cnt, k);
      end
      for (int j = 0; j < 5; j++) begin
        tick(16'h0601);
        total++;
        if (buzz !== (j == 4)) begin
          bad++; $display("FAIL snooze_tick%0d buzz=%b want=%0d", j, buzz, (j == 4));
        end
      end
    end
    press_snooze();
    total++;
    if (busy !== 1'b0 || buzz !== 1'b0 || snooze_cnt !== 2'd3) begin
      bad++; $display("FAIL snooze_max busy=%b buzz=%b cnt=%0d want 0 0 3", busy, buzz, snooze_cnt);
    end
  endtask

  task automatic test_auto_snooze();
    bit ok;
    int exp_slot;
    cfg(2'd3, 16'h0900, 1'b1);
    tick(16'h0900);
    exp_q.push_back(3);
    wait_busy(4, ok);
    exp_slot = exp_q.pop_front();
    total++;
    if (!ok || active_slot !== 2'(exp_slot)) begin
      bad++; $display("FAIL auto_start ok=%0d slot=%0d want %0d", ok, active_slot, exp_slot);
    end
    tick(16'h0901);
    total++;
    if (buzz !== 1'b1) begin
      bad++; $display("FAIL auto_tick1 buzz=%b want 1", buzz);
    end
    tick(16'h0902);
    total++;
    if (buzz !== 1'b0 || busy !== 1'b1 || snooze_cnt !== 2'd1) begin
      bad++; $display("FAIL auto_snooze buzz=%b busy=%b cnt=%0d want 0 1 1", buzz, busy, snooze_cnt);
    end
    for (int j = 0; j < 5; j++) tick(16'h0903);
    total++;
    if (buzz !== 1'b1) begin
      bad++; $display("FAIL auto_rering buzz=%b want 1", buzz);
    end
    STOP = 1'b1; Snooze = 1'b1; step(); STOP = 1'b0; Snooze = 1'b0;
    total++;
    if (busy !== 1'b0 || buzz !== 1'b0 || snooze_cnt !== 2'd1) begin
      bad++; $display("FAIL stop_wins busy=%b buzz=%b cnt=%0d want 0 0 1", busy, buzz, snooze_cnt);
    end
  endtask

  task automatic test_cfg_abort();
    bit ok;
    int exp_slot;
    cfg(2'd0, 16'h0600, 1'b1);
    tick(16'h0600);
    exp_q.push_back(0);
    wait_busy(4, ok);
    exp_slot = exp_q.pop_front();
    total++;
    if (!ok || active_slot !== 2'(exp_slot) || buzz !== 1'b1) begin
      bad++; $display("FAIL abort_start ok=%0d slot=%0d buzz=%b want slot %0d", ok, active_slot, buzz, exp_slot);
    end
    tick(16'h0600);
    total++;
    if (pending !== 4'b0000 || buzz !== 1'b1) begin
      bad++; $display("FAIL active_no_repend pend=%b buzz=%b want 0000 1", pending, buzz);
    end
    cfg(2'd0, 16'h0600, 1'b0);
    total++;
    if (busy !== 1'b0 || buzz !== 1'b0) begin
      bad++; $display("FAIL abort_disable busy=%b buzz=%b want 0 0", busy, buzz);
    end
    {DigN3, DigN2, DigN1, DigN0} = 16'h0900;
    minute_tick = 1'b1; cfg_wr = 1'b1; cfg_slot = 2'd3; cfg_time = 16'h0900; cfg_en = 1'b1;
    step();
    minute_tick = 1'b0; cfg_wr = 1'b0;
    total++;
    if (pending !== 4'b0000) begin
      bad++; $display("FAIL cfg_wins_match pend=%b want 0000", pending);
    end
    tick(16'h0600);
    step();
    total++;
    if (pending !== 4'b0000 || busy !== 1'b0) begin
      bad++; $display("FAIL disabled_match pend=%b busy=%b want 0000 0", pending, busy);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int exp_slot;
    tick(16'h0900);
    exp_q.push_back(3);
    wait_busy(4, ok);
    exp_slot = exp_q.pop_front();
    press_snooze();
    total++;
    if (!ok || active_slot !== 2'(exp_slot) || busy !== 1'b1 || buzz !== 1'b0) begin
      bad++; $display("FAIL midrst_snooze ok=%0d slot=%0d busy=%b buzz=%b want slot %0d 1 0",
                      ok, active_slot, busy, buzz, exp_slot);
    end
    reset_ = 1'b1; step(); reset_ = 1'b0;
    total++;
    if (buzz !== 1'b0 || busy !== 1'b0 || pending !== 4'b0 || snooze_cnt !== 2'd0) begin
      bad++; $display("FAIL midrst_clear buzz=%b busy=%b pend=%b cnt=%0d want all 0", buzz, busy, pending, snooze_cnt);
    end
    tick(16'h0900);
    step(); step();
    total++;
    if (buzz !== 1'b0 || busy !== 1'b0 || pending !== 4'b0) begin
      bad++; $display("FAIL midrst_slots_cleared buzz=%b busy=%b pend=%b want 0 0 0000", buzz, busy, pending);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_overlap();
    test_snooze();
    test_auto_snooze();
    test_cfg_abort();
    test_reset_mid();
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL scoreboard_leftover got=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
